// File: rtl/interpolate16.sv
// rtl/interpolate16.sv - linear 1:16 interpolator from low-rate unsigned samples to tick-rate output
//
// Purpose: takes IN_W-bit unsigned samples over a valid/ready handshake and, on each
// external tick, emits an OUT_W-bit sample that ramps linearly from the previous input
// sample to the current one over 2^LOG2_R ticks. A one-deep pending slot lets the
// source run ahead by one sample.
//
// Ports:
//   clk           system clock, posedge
//   rst_n         asynchronous active-low reset
//   sample        low-rate input sample
//   sample_valid  sample offered this cycle
//   sample_ready  block can accept (registered, no path from tick)
//   tick          one-cycle output-rate strobe
//   out_sample    interpolated output, registered
//   out_valid     one-cycle pulse, out_sample updated
//   underrun      one-cycle pulse, segment ended with no new sample available

module interpolate16 #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 12,
    parameter int LOG2_R = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  sample,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             tick,
    output logic [OUT_W-1:0] out_sample,
    output logic             out_valid,
    output logic             underrun
);

    localparam int SHIFT = LOG2_R + IN_W - OUT_W;
    localparam int ACC_W = IN_W + LOG2_R + 2;
    localparam int SCL_W = ACC_W - SHIFT;
    localparam logic [ACC_W-1:0] RND  = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [SCL_W-1:0] MAXV = {{(SCL_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [IN_W-1:0]    prev, prev_nxt;
    logic [IN_W-1:0]    cur, cur_nxt;
    logic [IN_W-1:0]    pend, pend_nxt;
    logic               pend_full, pend_full_nxt;
    logic [LOG2_R-1:0]  phase, phase_nxt;
    logic [OUT_W-1:0]   out_sample_nxt;
    logic               out_valid_nxt;
    logic               underrun_nxt;
    logic               ready_q;

    // ready is held in its own flop so it is 0 during reset and rises on the
    // first clock afterwards, while still tracking !pend_full one-for-one.
    assign sample_ready = ready_q;

    // acc = prev*2^LOG2_R + (cur-prev)*phase; the signed difference keeps
    // descending ramps exact, and the sum is never negative.
    logic signed [IN_W:0]    diff;
    logic signed [ACC_W-1:0] base, diff_w, phase_w, prod, acc;
    logic        [ACC_W-1:0] rnd;
    logic        [SCL_W-1:0] scaled;
    logic        [OUT_W-1:0] sat;

    assign diff    = {1'b0, cur} - {1'b0, prev};
    assign base    = {2'b00, prev, {LOG2_R{1'b0}}};
    assign diff_w  = {{(ACC_W-IN_W-1){diff[IN_W]}}, diff};
    assign phase_w = {{(ACC_W-LOG2_R){1'b0}}, phase};
    assign prod    = diff_w * phase_w;
    assign acc     = base + prod;
    assign rnd     = $unsigned(acc) + RND;
    assign scaled  = rnd[ACC_W-1:SHIFT];
    // Rounding can carry a full-scale input past OUT_W bits; clamp instead of wrapping.
    assign sat     = (scaled > MAXV) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];

    logic accept, seg_end;
    assign accept  = sample_valid && ready_q;
    assign seg_end = tick && (phase == {LOG2_R{1'b1}});

    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        cur_nxt        = cur;
        pend_nxt       = pend;
        pend_full_nxt  = pend_full;
        phase_nxt      = phase;
        out_sample_nxt = out_sample;
        out_valid_nxt  = 1'b0;
        underrun_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    prev_nxt  = sample;
                    cur_nxt   = sample;
                    phase_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    out_sample_nxt = sat;
                    out_valid_nxt  = 1'b1;
                    phase_nxt      = phase + 1'b1;
                end
                if (seg_end) begin
                    prev_nxt = cur;
                    if (pend_full) begin
                        cur_nxt       = pend;
                        pend_full_nxt = 1'b0;
                    end else if (accept) begin
                        // Sample arriving exactly at the boundary bypasses the pending slot.
                        cur_nxt = sample;
                    end else begin
                        underrun_nxt = 1'b1;
                    end
                end else if (accept) begin
                    pend_nxt      = sample;
                    pend_full_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            cur        <= '0;
            pend       <= '0;
            pend_full  <= 1'b0;
            phase      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            underrun   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            prev       <= prev_nxt;
            cur        <= cur_nxt;
            pend       <= pend_nxt;
            pend_full  <= pend_full_nxt;
            phase      <= phase_nxt;
            out_sample <= out_sample_nxt;
            out_valid  <= out_valid_nxt;
            underrun   <= underrun_nxt;
            ready_q    <= !pend_full_nxt;
        end
    end

endmodule
